float_mul_seq: RTL and testbench
================================

Name: float_mul_seq

Overview:
- Sequential IEEE-754-style floating-point multiplier. Exponent and mantissa widths are parameters; 32-bit single precision is the default.
- Successor to the float_pkg helpers: adds a valid/ready handshake, an iterative shift-add significand multiply, normalisation, round-to-nearest-even, special-value handling and exception flags.
- Sits in front of float datapath consumers. One operation in flight at a time.

Parameters:
- BiasedExponentWidth, 8, exponent field width E (min 3).
- MantissaWidth, 23, stored mantissa width M (min 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a_i  in  1+E+M  operand A {sign, biased_exponent, mantissa}.
- b_i  in  1+E+M  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result_o  out  1+E+M  product.
- flags_o  out  4  {invalid, overflow, underflow, inexact}; valid with out_valid.

Behaviour:
- Reset (synchronous, active-high, one clock):
  - state=IDLE, in_ready=1, out_valid=0, result_o=0, flags_o=0.
  - Any in-flight operation is discarded, including a reset mid-MUL.
- Handshake:
  - An operand pair is accepted on the edge where in_valid && in_ready.
  - in_ready=1 only in IDLE.
  - out_valid holds in DONE until out_ready. result_o and flags_o are stable while out_valid && !out_ready.
  - DONE with out_ready returns to IDLE on the next edge. There is no accept in the same cycle as the result drain.
- Classification on accept: zero, subnormal, normal, inf, NaN. Bias = 2^(E-1)-1.
- Special path (IDLE->DONE, out_valid one cycle after accept):
  - NaN operand, or inf*0 -> canonical qNaN {0, all ones, 1 followed by zeros}. invalid=1 only for inf*0 or a signalling NaN input.
  - inf*finite-nonzero -> signed inf, flags 0.
  - zero*finite -> signed zero, flags 0.
  - Sign = a.sign ^ b.sign, except NaN.
- Normal path states: IDLE -> MUL -> NORM -> ROUND -> DONE.
  - MUL, exactly M+1 cycles: shift-add of two (M+1)-bit significands (hidden bit = biased_exponent!=0) into a 2M+2-bit product.
  - MUL exponent: signed width E+2, ea+eb-Bias. A subnormal operand uses effective exponent 1.
  - NORM:
    - If product MSB is set: shift right 1 into sticky, exp+1, one cycle.
    - Else: shift left 1 per cycle while bit 2M is 0 and exp > 1 (subnormal operands only). Minimum 1 cycle.
  - ROUND, 1 cycle:
    - If exp < 1: barrel right shift by 1-exp with sticky (SUBNORMAL_EN; see Optional Feature).
    - Round nearest-even on guard/round/sticky.
    - Mantissa carry-out increments exp.
    - exp >= 2^E-1 -> signed inf, overflow=1, inexact=1.
- Latency: normal*normal non-special gives out_valid exactly M+4 cycles after the accept edge (27 for the default widths).
- inexact=1 whenever any discarded bit is nonzero.

Optional Feature:
- Macro FLOAT_MUL_SUBNORMAL_EN.
- Defined:
  - Subnormal inputs are used as-is.
  - Tiny results are denormalised in ROUND; underflow=1 when the result is tiny and inexact.
- Undefined:
  - Subnormal inputs are treated as signed zero (special path).
  - Results with exp < 1 after rounding flush to signed zero, with underflow=1 and inexact=1.
  - The NORM left-shift loop is never entered.

Decomposition:
- float_pkg gains:
  - a state enum (IDLE, MUL, NORM, ROUND, DONE);
  - a class enum (ZERO, SUB, NORMAL, INF, NAN);
  - a flag struct {invalid, overflow, underflow, inexact}.
- float_t stays the default-width alias. The module builds its own packed struct from its parameters.
- One sub-module, float_sig_mul_seq: the iterative (M+1)x(M+1) shift-add multiplier with start/done handshake and an M+1 cycle count.

Test Plan:
- 0x3FC00000 * 0x40000000 -> 0x40400000, flags 0, out_valid exactly 27 cycles after accept.
- 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1 only (round-nearest-even, tie not hit).
- 0x7F7FFFFF * 0x40000000 -> 0x7F800000, overflow=1, inexact=1. 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1, 1-cycle latency.
- 0x00000001 * 0x3F800000:
  - with FLOAT_MUL_SUBNORMAL_EN -> 0x00000001, flags 0;
  - without -> 0x00000000, flags 0.
  - 0x00800000 * 0x3F000000 without the macro -> 0x00000000, underflow=1, inexact=1.
- Hold out_ready=0 for 5 cycles after out_valid -> result_o and flags_o stable, in_ready=0. Then drain, and in_ready=1 on the next cycle.
- Assert rst for 1 cycle at MUL cycle 10 -> next cycle in_ready=1, out_valid=0. A new op 0x40000000 * 0x40000000 -> 0x40800000 after 27 cycles.

Source files
------------

// File: rtl/float_pkg.sv
// Shared floating-point types: the default single-precision alias plus the state,
// class and exception-flag types used by the sequential multiplier.
package float_pkg;

    localparam int FLOAT_E = 8;
    localparam int FLOAT_M = 23;

    typedef struct packed {
        logic               sign;
        logic [FLOAT_E-1:0] exp;
        logic [FLOAT_M-1:0] man;
    } float_t;

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} mul_state_e;

    typedef enum logic [2:0] {ZERO, SUB, NORMAL, INF, NAN} float_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } float_flags_t;

endpackage

// File: rtl/float_sig_mul_seq.sv
// Iterative shift-add significand multiplier: one partial product per cycle,
// Width cycles from start to a one-cycle done pulse with the full product held.
module float_sig_mul_seq #(
    parameter int Width = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [Width-1:0]     a,
    input  logic [Width-1:0]     b,
    output logic                 done,
    output logic [2*Width-1:0]   product
);

    localparam int CntW = $clog2(Width);
    localparam logic [CntW-1:0] LAST = CntW'(Width - 1);

    logic [Width-1:0]   mcand_q;
    logic [2*Width-1:0] acc_q;
    logic [CntW-1:0]    count_q;
    logic               busy_q;
    logic               done_q;

    // Upper half accumulates; multiplier bits drain out of the lower half.
    function automatic logic [2*Width-1:0] step(input logic [2*Width-1:0] acc,
                                                input logic [Width-1:0]   mcand);
        logic [Width:0] sum;
        sum = {1'b0, acc[2*Width-1:Width]} + (acc[0] ? {1'b0, mcand} : '0);
        return {sum, acc[Width-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                busy_q  <= 1'b1;
                count_q <= CntW'(1);
            end else if (busy_q) begin
                count_q <= count_q + 1'b1;
                if (count_q == LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // NOTE: datapath registers carry no reset; busy/done decide when they mean anything.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_q <= a;
            acc_q   <= step({{Width{1'b0}}, b}, a);
        end else if (busy_q) begin
            acc_q   <= step(acc_q, mcand_q);
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/float_mul_seq.sv
// Sequential IEEE-754-style multiplier with valid/ready handshake and RNE rounding.
// Define FLOAT_MUL_SUBNORMAL_EN to keep subnormal operands and denormalise tiny results.
module float_mul_seq
    import float_pkg::*;
#(
    parameter int BiasedExponentWidth = 8,
    parameter int MantissaWidth       = 23
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [BiasedExponentWidth+MantissaWidth:0]    a_i,
    input  logic [BiasedExponentWidth+MantissaWidth:0]    b_i,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [BiasedExponentWidth+MantissaWidth:0]    result_o,
    output logic [3:0]                                    flags_o
);

    localparam int E  = BiasedExponentWidth;
    localparam int M  = MantissaWidth;
    localparam int PW = 2*M + 2;
    localparam int RW = 2*M + 1;

    localparam logic signed [E+1:0] BIAS    = (E+2)'((1 << (E-1)) - 1);
    localparam logic signed [E+1:0] EXP_ONE = (E+2)'(1);
    localparam logic signed [E+1:0] EXP_INF = (E+2)'((1 << E) - 1);

    typedef struct packed {
        logic         sign;
        logic [E-1:0] exp;
        logic [M-1:0] man;
    } fp_t;

    function automatic float_class_e classify(input fp_t f);
        if (f.exp == '1) return (f.man == '0) ? INF : NAN;
        if (f.exp == '0) begin
`ifdef FLOAT_MUL_SUBNORMAL_EN
            return (f.man == '0) ? ZERO : SUB;
`else
            return ZERO;
`endif
        end
        return NORMAL;
    endfunction

    mul_state_e          state_q, state_d;
    fp_t                 a_op, b_op;
    float_class_e        cls_a, cls_b;
    logic                accept, special, mul_start, mul_done;
    logic [PW-1:0]       mul_product;
    fp_t                 spec_res;
    float_flags_t        spec_flags;
    logic signed [E+1:0] ea_eff, eb_eff;

    logic                sign_q, sticky_q;
    logic signed [E+1:0] exp_q;
    logic [PW-1:0]       sig_q;
    fp_t                 result_q;
    float_flags_t        flags_q;

    logic                norm_shr, norm_shl;
    logic [RW-1:0]       rnd_sig;
    logic                rnd_sticky, guard, rest, round_up, hidden;
    logic signed [E+1:0] rnd_exp, exp_r;
    logic [M+1:0]        sig_r;
    logic [M-1:0]        frac;
    fp_t                 rnd_res;
    float_flags_t        rnd_flags;

    assign a_op      = a_i;
    assign b_op      = b_i;
    assign cls_a     = classify(a_op);
    assign cls_b     = classify(b_op);
    assign accept    = in_valid && (state_q == IDLE);
    assign mul_start = accept && !special;
    assign ea_eff    = (a_op.exp == '0) ? EXP_ONE : signed'({2'b00, a_op.exp});
    assign eb_eff    = (b_op.exp == '0) ? EXP_ONE : signed'({2'b00, b_op.exp});

    always_comb begin
        spec_res   = '0;
        spec_flags = '0;
        special    = 1'b1;
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            spec_res.exp       = '1;
            spec_res.man       = {1'b1, {(M-1){1'b0}}};
            spec_flags.invalid = (cls_a == NAN && !a_op.man[M-1]) ||
                                 (cls_b == NAN && !b_op.man[M-1]) ||
                                 (cls_a != NAN && cls_b != NAN);
        end else if (cls_a == INF || cls_b == INF) begin
            spec_res.sign = a_op.sign ^ b_op.sign;
            spec_res.exp  = '1;
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            spec_res.sign = a_op.sign ^ b_op.sign;
        end else begin
            special = 1'b0;
        end
    end

    float_sig_mul_seq #(.Width(M + 1)) u_sig_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       ({a_op.exp != '0, a_op.man}),
        .b       ({b_op.exp != '0, b_op.man}),
        .done    (mul_done),
        .product (mul_product)
    );

    assign norm_shr = sig_q[PW-1];
`ifdef FLOAT_MUL_SUBNORMAL_EN
    assign norm_shl = !sig_q[PW-1] && !sig_q[2*M] && (exp_q > EXP_ONE);
`else
    assign norm_shl = 1'b0;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: default assignment first, so no path through the case leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : MUL;
            MUL:     if (mul_done) state_d = NORM;
            NORM:    if (!norm_shl) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result_o  = result_q;
        flags_o   = flags_q;
    end

    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: if (accept) begin
                sign_q <= a_op.sign ^ b_op.sign;
                exp_q  <= ea_eff + eb_eff - BIAS;
            end
            MUL: if (mul_done) begin
                sig_q    <= mul_product;
                sticky_q <= 1'b0;
            end
            NORM: begin
                if (norm_shr) begin
                    sig_q    <= sig_q >> 1;
                    sticky_q <= sticky_q | sig_q[0];
                    exp_q    <= exp_q + EXP_ONE;
                end else if (norm_shl) begin
                    sig_q    <= sig_q << 1;
                    exp_q    <= exp_q - EXP_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (state_q == IDLE && accept && special) begin
            result_q <= spec_res;
            flags_q  <= spec_flags;
        end else if (state_q == ROUND) begin
            result_q <= rnd_res;
            flags_q  <= rnd_flags;
        end
    end

`ifdef FLOAT_MUL_SUBNORMAL_EN
    logic signed [E+1:0] shamt;
    logic                tiny;
`endif

    // Leading one sits at bit 2M after NORM unless the result is subnormal.
    always_comb begin
        rnd_sig    = sig_q[RW-1:0];
        rnd_sticky = sticky_q;
        rnd_exp    = exp_q;
`ifdef FLOAT_MUL_SUBNORMAL_EN
        shamt = EXP_ONE - exp_q;
        tiny  = (exp_q < EXP_ONE) || !sig_q[2*M];
        if (exp_q < EXP_ONE) begin
            if (int'(shamt) >= RW) begin
                rnd_sig    = '0;
                rnd_sticky = sticky_q | (|sig_q[RW-1:0]);
            end else begin
                rnd_sig    = sig_q[RW-1:0] >> shamt;
                rnd_sticky = sticky_q | (|(sig_q[RW-1:0] & ~({RW{1'b1}} << shamt)));
            end
            rnd_exp = EXP_ONE;
        end
`endif
        guard    = rnd_sig[M-1];
        rest     = (|rnd_sig[M-2:0]) | rnd_sticky;
        round_up = guard & (rest | rnd_sig[M]);
        sig_r    = {1'b0, rnd_sig[2*M:M]} + {{(M+1){1'b0}}, round_up};
        if (sig_r[M+1]) begin
            frac   = sig_r[M:1];
            exp_r  = rnd_exp + EXP_ONE;
            hidden = 1'b1;
        end else begin
            frac   = sig_r[M-1:0];
            exp_r  = rnd_exp;
            hidden = sig_r[M];
        end
        rnd_res.sign      = sign_q;
        rnd_res.exp       = hidden ? exp_r[E-1:0] : '0;
        rnd_res.man       = frac;
        rnd_flags         = '0;
        rnd_flags.inexact = guard | rest;
        if (exp_r >= EXP_INF) begin
            rnd_res.exp        = '1;
            rnd_res.man        = '0;
            rnd_flags.overflow = 1'b1;
            rnd_flags.inexact  = 1'b1;
        end
`ifdef FLOAT_MUL_SUBNORMAL_EN
        else begin
            rnd_flags.underflow = tiny & (guard | rest);
        end
`else
        else if (exp_r < EXP_ONE) begin
            rnd_res.exp         = '0;
            rnd_res.man         = '0;
            rnd_flags.underflow = 1'b1;
            rnd_flags.inexact   = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_float_mul_seq.sv
// Scoreboard bench for float_mul_seq (default widths); expectations follow
// FLOAT_MUL_SUBNORMAL_EN when the build defines it.
module tb_float_mul_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a_i, b_i, result_o;
    logic [3:0]  flags_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];

    float_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .flags_o   (flags_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // Drive one operand pair, wait for its result, compare against the queue head,
    // optionally stall the consumer for `hold` cycles, then drain.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] flags,
                         input int lat, input int hold);
        exp_t        e;
        int          n;
        logic [31:0] held_res;
        logic [3:0]  held_flags;
        sb.push_back('{a, b, res, flags, lat});
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a_i      = a;
        b_i      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        check("out_valid_seen", {31'b0, out_valid}, 32'd1);
        check("result", result_o, e.res);
        check("flags", {28'b0, flags_o}, {28'b0, e.flags});
        if (e.lat != 0) check("latency", n, e.lat);
        held_res   = result_o;
        held_flags = flags_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_result", result_o, held_res);
            check("hold_flags", {28'b0, flags_o}, {28'b0, held_flags});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_out_valid", {31'b0, out_valid}, 32'd0);
        check("drain_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result_o, 32'h0);
        check("reset_flags", {28'b0, flags_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 0);
        do_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27, 0);
        do_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 27, 0);
        do_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, 0);
        do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 27, 0);
        do_op(32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000, 27, 0);
        do_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 27, 0);
        do_op(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 27, 0);
        do_op(32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1, 0);
        do_op(32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 1, 0);
        do_op(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, 0);
        do_op(32'hFFC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 1, 0);
`ifdef FLOAT_MUL_SUBNORMAL_EN
        do_op(32'h00000001, 32'h3F800000, 32'h00000001, 4'b0000, 0, 0);
        do_op(32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000, 27, 0);
`else
        do_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1, 0);
        do_op(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 27, 0);
`endif
        do_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27, 5);

        // Reset in the tenth MUL cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a_i      = 32'h40000000;
        b_i      = 32'h40000000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midmul_reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("midmul_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midmul_reset_result", result_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 27, 0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
